// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: FSM states, frame constants, parity helper
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int BIT_TICKS = 16;
  localparam int DATA_BITS = 8;

  // Bit that makes the total count of ones in data plus parity odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~(^b);
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - byte write port of the UART transmitter
interface uart_tx_if;
  logic [7:0] data_in;
  logic       data_wr;
  logic       full;
  logic       overflow;
  logic       busy;

  modport master (output data_in, data_wr, input full, overflow, busy);
  modport slave  (input data_in, data_wr, output full, overflow, busy);
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous byte FIFO feeding the UART transmitter
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1/8O1 UART transmitter on the 16x baud_clk
// UART_TX_FIFO_EN selects a FIFO_DEPTH-entry FIFO instead of a single holding register.
module uart_tx
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       baud_clk,
  input  logic       rst_n,
  input  logic       parity_en,
  uart_tx_if.slave   wr,
  output logic       tx,
  output logic       tx_done
);
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("uart_tx: FIFO_DEPTH must be a power of two >= 2");
  end

  uart_state_e state_q, state_d;
  logic [3:0]  tick_q, tick_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_en_q, par_en_d;
  logic        tx_d;
  logic        done_d;
  logic        last_tick;
  logic        push;
  logic        pop;
  logic        buf_full;
  logic        buf_empty;
  logic        buf_pending;
  logic [7:0]  buf_data;

  // full is judged before any same-cycle pop, so a write while full is always dropped.
  assign push        = wr.data_wr & ~buf_full;
  assign wr.full     = buf_full;
  assign wr.overflow = wr.data_wr & buf_full;
  assign wr.busy     = (state_q != IDLE) | buf_pending;

`ifdef UART_TX_FIFO_EN
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (baud_clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (wr.data_in),
    .dout  (buf_data),
    .full  (buf_full),
    .empty (buf_empty),
    .count (fifo_count)
  );
  assign buf_pending = (fifo_count != '0);
`else
  logic       hold_valid;
  logic [7:0] hold_data;

  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (push) begin
      hold_valid <= 1'b1;
      hold_data  <= wr.data_in;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  assign buf_full    = hold_valid;
  assign buf_empty   = ~hold_valid;
  assign buf_pending = hold_valid;
  assign buf_data    = hold_data;
`endif

  assign last_tick = (tick_q == 4'(BIT_TICKS - 1));

  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      tx        <= 1'b1;
      tx_done   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      tx        <= tx_d;
      tx_done   <= done_d;
    end
  end

  // The line level is registered from the current state, so tx trails the FSM by one clock.
  always_comb begin
    state_d   = state_q;
    tick_d    = (state_q == IDLE) ? 4'd0 : tick_q + 4'd1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    tx_d      = 1'b1;
    done_d    = 1'b0;
    pop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!buf_empty) begin
          pop      = 1'b1;
          shift_d  = buf_data;
          par_en_d = parity_en;
          state_d  = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (last_tick) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        tx_d = shift_q[bit_idx_q];
        if (last_tick) begin
          if (bit_idx_q == 3'(DATA_BITS - 1)) state_d = par_en_q ? PARITY : STOP;
          else                                bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      PARITY: begin
        tx_d = odd_parity(shift_q);
        if (last_tick) state_d = STOP;
      end
      STOP: begin
        tx_d = 1'b1;
        if (last_tick) begin
          done_d = 1'b1;
          if (!buf_empty) begin
            pop      = 1'b1;
            shift_d  = buf_data;
            par_en_d = parity_en;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - randomized self-checking bench for uart_tx with a line-decoding reference
module tb_uart_tx;
  import uart_pkg::*;

  localparam int FIFO_DEPTH = 4;
`ifdef UART_TX_FIFO_EN
  localparam int CAP = FIFO_DEPTH;
`else
  localparam int CAP = 1;
`endif

  logic baud_clk;
  logic rst_n;
  logic parity_en;
  logic tx;
  logic tx_done;
  int   cyc;

  uart_tx_if bus ();

  uart_tx #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .baud_clk  (baud_clk),
    .rst_n     (rst_n),
    .parity_en (parity_en),
    .wr        (bus),
    .tx        (tx),
    .tx_done   (tx_done)
  );

  initial baud_clk = 1'b0;
  always #5 baud_clk = ~baud_clk;
  always @(posedge baud_clk) cyc <= cyc + 1;

  int   n_checks;
  int   n_fail;
  logic [7:0] exp_q[$];
  logic       exp_par_q[$];
  int   starts[$];
  int   done_total;
  bit   in_frame;
  logic last_rp;
  int   last_len;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int ones(input logic [7:0] b);
    int n = 0;
    for (int k = 0; k < 8; k++) n += int'(b[k]);
    return n;
  endfunction

  // Reference receiver: builds the ideal frame from the queued byte and compares every clock.
  task automatic run_frame();
    logic [7:0] eb, rb;
    logic       ep, rp, rs;
    logic       fb [11];
    int         nslots, len, err, done_n, done_at, slot;
    bit         aborted;
    in_frame = 1;
    starts.push_back(cyc);
    if (exp_q.size() == 0) begin
      check("unexpected_frame", 32'd1, 32'd0);
      eb = '0;
      ep = 1'b0;
    end else begin
      eb = exp_q.pop_front();
      ep = exp_par_q.pop_front();
    end
    nslots = ep ? 11 : 10;
    len    = nslots * 16;
    fb[0]  = 1'b0;
    for (int k = 0; k < 8; k++) fb[1 + k] = eb[k];
    fb[9]  = ep ? ((ones(eb) % 2 == 0) ? 1'b1 : 1'b0) : 1'b1;
    fb[10] = 1'b1;
    err = 0; done_n = 0; done_at = -1; aborted = 0;
    rb = '0; rp = 1'b0; rs = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (i > 0) @(negedge baud_clk);
      if (rst_n !== 1'b1) begin
        aborted = 1;
        break;
      end
      if (tx !== fb[i / 16]) err++;
      if (tx_done === 1'b1) begin
        done_n++;
        done_at = i;
      end
      if (i % 16 == 8) begin
        slot = i / 16;
        if (slot >= 1 && slot <= 8) rb[slot - 1] = tx;
        else if (slot == 9 && ep)   rp = tx;
        if (slot == nslots - 1)     rs = tx;
      end
    end
    if (!aborted) begin
      check("frame_line_errors", err, 0);
      check("rx_data", rb, eb);
      check("rx_frame_err", rs, 1'b1);
      if (ep) check("rx_parity_err", (ones(rb) + int'(rp)) % 2, 1);
      check("tx_done_count", done_n, 1);
      check("tx_done_pos", done_at, len - 1);
      done_total += done_n;
      last_rp  = rp;
      last_len = done_at + 1;
    end
    in_frame = 0;
  endtask

  initial begin : monitor
    forever begin
      @(negedge baud_clk);
      if (rst_n === 1'b1) begin
        if (tx_done === 1'b1) check("tx_done_outside_frame", tx_done, 1'b0);
        if (tx === 1'b0) run_frame();
      end
    end
  end

  task automatic push(input logic [7:0] b);
    int n = 0;
    while (bus.full === 1'b1 && n < 1000) begin
      @(negedge baud_clk);
      n++;
    end
    if (bus.full !== 1'b0) check("push_timeout", 32'd1, 32'd0);
    bus.data_in = b;
    bus.data_wr = 1'b1;
    exp_q.push_back(b);
    exp_par_q.push_back(parity_en);
    @(negedge baud_clk);
    bus.data_wr = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || in_frame) && n < 20000) begin
      @(negedge baud_clk);
      n++;
    end
    check("idle_timeout", (exp_q.size() != 0 || in_frame), 0);
    @(negedge baud_clk);
    check("busy_after_frames", bus.busy, 1'b0);
    check("tx_idle_high", tx, 1'b1);
  endtask

  task automatic wait_frame();
    int n = 0;
    while (!in_frame && n < 200) begin
      @(negedge baud_clk);
      n++;
    end
    check("frame_start_timeout", in_frame, 1'b1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int s0, d0;
    logic [7:0] b;
    bit exp_full;
    n_checks = 0; n_fail = 0; done_total = 0; in_frame = 0; cyc = 0;
    rst_n = 1'b0; parity_en = 1'b0;
    bus.data_in = '0; bus.data_wr = 1'b0;
    repeat (3) @(negedge baud_clk);
    check("reset_tx", tx, 1'b1);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_full", bus.full, 1'b0);
    check("reset_tx_done", tx_done, 1'b0);
    check("reset_overflow", bus.overflow, 1'b0);
    rst_n = 1'b1;
    @(negedge baud_clk);

    // Single frame, no parity.
    push(8'h55);
    wait_idle();
    check("len_noparity", last_len, 160);

    // Odd parity slot values and a mid-frame parity_en change.
    parity_en = 1'b1;
    push(8'h00); wait_idle();
    check("par_slot_00", last_rp, 1'b1);
    check("len_parity_00", last_len, 176);
    push(8'h01); wait_idle();
    check("par_slot_01", last_rp, 1'b0);
    push(8'hFF);
    wait_frame();
    repeat (30) @(negedge baud_clk);
    parity_en = 1'b0;
    wait_idle();
    check("par_slot_ff", last_rp, 1'b1);
    check("len_parity_ff", last_len, 176);

    // Back-to-back frames.
    s0 = starts.size(); d0 = done_total;
    push(8'hA1); push(8'hB2); push(8'hC3);
    wait_idle();
    check("b2b_frames", starts.size() - s0, 3);
    check("b2b_done_pulses", done_total - d0, 3);
    if (starts.size() - s0 == 3) begin
      check("b2b_gap_1", starts[s0 + 1] - starts[s0], 160);
      check("b2b_gap_2", starts[s0 + 2] - starts[s0 + 1], 160);
    end

    // Overflow while a frame is in flight.
    push(8'h11);
    wait_frame();
    repeat (20) @(negedge baud_clk);
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      exp_full = (i >= CAP);
      bus.data_in = b;
      bus.data_wr = 1'b1;
      #1;
      check("ovf_full", bus.full, exp_full);
      check("ovf_pulse", bus.overflow, exp_full);
      if (!exp_full) begin
        exp_q.push_back(b);
        exp_par_q.push_back(parity_en);
      end
      @(negedge baud_clk);
    end
    bus.data_wr = 1'b0;
    #1;
    check("ovf_full_held", bus.full, 1'b1);
    check("ovf_idle_no_pulse", bus.overflow, 1'b0);
    @(negedge baud_clk);
    wait_idle();

    // Reset during DATA bit 3 with a byte still buffered.
    push(8'($urandom));
    wait_frame();
    push(8'($urandom));
    repeat (68) @(negedge baud_clk);
    d0 = done_total;
    @(posedge baud_clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_tx", tx, 1'b1);
    check("rst_mid_busy", bus.busy, 1'b0);
    check("rst_mid_full", bus.full, 1'b0);
    repeat (4) @(negedge baud_clk);
    check("rst_mid_tx_done", tx_done, 1'b0);
    rst_n = 1'b1;
    exp_q.delete();
    exp_par_q.delete();
    check("rst_mid_no_done", done_total - d0, 0);
    @(negedge baud_clk);
    push(8'h3C);
    wait_idle();

    // Randomized loopback with each parity setting.
    for (int p = 0; p < 2; p++) begin
      parity_en = p[0];
      for (int n = 0; n < 64; n++) begin
        if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 40)) @(negedge baud_clk);
        push(8'($urandom));
      end
      wait_idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
